// File: rtl/dmem_sys.sv
// dmem_sys: data RAM, console FIFO, cycle counter and tohost halt register behind a single-cycle MEM-stage port
module dmem_sys #(
  parameter int    DEPTH     = 1024,
  parameter int    CON_DEPTH = 4,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_mem_addr,
  input  logic [3:0]  MEM_mem_cmd,
  input  logic [31:0] MEM_mem_din,
  output logic [31:0] DM_mem_dout,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CON_DEPTH);
  logic [31:0] mem [DEPTH];
  logic [7:0] fifo_q [CON_DEPTH];
  logic [CW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW:0] cnt_q, cnt_d;
  logic [31:0] cycle_q, cycle_d, halt_code_q, halt_code_d, wdata;
  logic halt_q, halt_d, err_q, err_d;
  logic is_ld, is_st, in_ram, a_con, a_stat, a_cyc, a_toh, mapped, misal;
  logic st_ok, push, pop, full, wr_en, toh_wr;
  logic [3:0] mask;
  logic [AW-1:0] widx;
  always_comb begin
    is_ld = MEM_mem_cmd[3:2] == 2'b01;
    is_st = MEM_mem_cmd[3:2] == 2'b10;
    in_ram = MEM_mem_addr[31:AW+2] == '0;
    a_con = MEM_mem_addr == 32'h8000_0000;
    a_stat = MEM_mem_addr == 32'h8000_0004;
    a_cyc = MEM_mem_addr == 32'h8000_0008;
    a_toh = MEM_mem_addr == 32'h8000_000C;
    mapped = in_ram | a_con | a_stat | a_cyc | a_toh;
    misal = MEM_mem_cmd[1:0] == 2'b00 ? 1'b0 :
            MEM_mem_cmd[1:0] == 2'b01 ? MEM_mem_addr[0] : |MEM_mem_addr[1:0];
    mask = (MEM_mem_cmd[1:0] == 2'b00 ? 4'b0001 :
            MEM_mem_cmd[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << MEM_mem_addr[1:0];
    wdata = MEM_mem_din << {MEM_mem_addr[1:0], 3'b000};
    widx = MEM_mem_addr[AW+1:2];
    st_ok = is_st & ~misal;
    full = cnt_q == (CW+1)'(CON_DEPTH);
    con_valid = cnt_q != '0;
    con_data = con_valid ? fifo_q[rd_q] : 8'h00;
    pop = con_valid & con_ready;
    push = st_ok & a_con;
    wr_en = push & (~full | pop);
    toh_wr = st_ok & a_toh & MEM_mem_cmd[1];
    rd_d = rd_q + CW'(pop);
    wr_d = wr_q + CW'(wr_en);
    cnt_d = cnt_q + (CW+1)'(wr_en) - (CW+1)'(pop);
    cycle_d = cycle_q + 32'd1;
    halt_d = halt_q | toh_wr;
    halt_code_d = toh_wr ? MEM_mem_din : halt_code_q;
    err_d = err_q | (is_ld & ~mapped) | (is_st & (misal | ~mapped)) | (push & full & ~pop);
    DM_mem_dout = !is_ld ? '0 : in_ram ? mem[widx] :
                  a_stat ? {27'b0, full, 4'(cnt_q)} : a_cyc ? cycle_q : '0;
    halt = halt_q;
    halt_code = halt_code_q;
    err = err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      cycle_q <= '0;
      halt_q <= 1'b0;
      halt_code_q <= '0;
      err_q <= 1'b0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      cycle_q <= cycle_d;
      halt_q <= halt_d;
      halt_code_q <= halt_code_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && st_ok && in_ram)
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[widx][8*i+:8] <= wdata[8*i+:8];
    if (!rst && wr_en) fifo_q[wr_q] <= MEM_mem_din[7:0];
  end
endmodule

// File: tb/tb_dmem_sys.sv
// tb_dmem_sys: directed scoreboard bench for dmem_sys
module tb_dmem_sys;
  localparam logic [1:0] NO = 2'b00, LD = 2'b01, ST = 2'b10;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;
  localparam logic [31:0] CON = 32'h8000_0000, STAT = 32'h8000_0004;
  localparam logic [31:0] CYC = 32'h8000_0008, TOH = 32'h8000_000C;

  logic clk = 1'b0, rst = 1'b1, con_ready = 1'b0;
  logic [31:0] addr = '0, din = '0;
  logic [3:0] cmd = '0;
  logic [31:0] dout, halt_code;
  logic con_valid, halt, err;
  logic [7:0] con_data;

  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sb[$];
  logic [7:0] con_q[$];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dmem_sys #(.DEPTH(1024), .CON_DEPTH(4), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .MEM_mem_addr(addr), .MEM_mem_cmd(cmd),
    .MEM_mem_din(din), .DM_mem_dout(dout), .con_valid(con_valid),
    .con_data(con_data), .con_ready(con_ready), .halt(halt),
    .halt_code(halt_code), .err(err)
  );

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] e);
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic drv(input string tag, input logic [1:0] op, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    exp_t x;
    cmd = {op, sz};
    addr = a;
    din = d;
    sb.push_back('{tag, e});
    #2;
    x = sb.pop_front();
    ck(x.tag, dout, x.v);
  endtask

  task automatic go(input string tag, input logic [1:0] op, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    @(negedge clk);
    drv(tag, op, sz, a, d, e);
  endtask

  task automatic con_chk();
    if (con_valid && con_ready)
      ck("con_data", {24'b0, con_data}, con_q.size() != 0 ? {24'b0, con_q.pop_front()} : 32'hxxxx_xxxx);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      con_ready = 1'b1;
      drv("drain_idle", NO, W, 0, 0, 0);
      if (!con_valid) break;
      con_chk();
    end
    ck("con_empty", {31'b0, con_valid}, 0);
    ck("sb_left", con_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cmd = {ST, B};
    addr = CON;
    din = 32'h5A;
    @(negedge clk);
    cmd = '0;
    @(negedge clk);
    rst = 1'b0;
    con_ready = 1'b0;
    con_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    ck("rst_valid", {31'b0, con_valid}, 0);
    ck("rst_data", {24'b0, con_data}, 0);
    ck("rst_halt", {31'b0, halt}, 0);
    ck("rst_code", halt_code, 0);
    ck("rst_err", {31'b0, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    drv("cyc_first", LD, W, CYC, 0, 0);
    repeat (9) go("idle", NO, W, 0, 0, 0);
    go("cyc_plus10", LD, W, CYC, 0, 10);

    go("sw10", ST, W, 32'h10, 32'h1122_3344, 0);
    go("lw10_a", LD, W, 32'h10, 0, 32'h1122_3344);
    go("sb11", ST, B, 32'h11, 32'hAA, 0);
    go("sh12", ST, H, 32'h12, 32'hBEEF, 0);
    go("lw10_b", LD, W, 32'h10, 0, 32'hBEEF_AA44);
    go("lb13_word", LD, B, 32'h13, 0, 32'hBEEF_AA44);
    go("st_cyc", ST, W, CYC, 5, 0);
    go("st_stat", ST, W, STAT, 5, 0);
    go("idle", NO, W, 0, 0, 0);
    ck("ro_err", {31'b0, err}, 0);

    for (int i = 0; i < 4; i++) begin
      go("push", ST, B, CON, 32'h41 + i, 0);
      con_q.push_back(8'(8'h41 + i));
      if (i == 0) ck("valid_pre", {31'b0, con_valid}, 0);
      if (i == 1) ck("head_A", {24'b0, con_data}, 32'h41);
    end
    go("stat_full", LD, W, STAT, 0, 32'h14);
    ck("err_pre_ovf", {31'b0, err}, 0);
    go("push_E", ST, B, CON, 32'h45, 0);
    go("stat_ovf", LD, W, STAT, 0, 32'h14);
    ck("err_ovf", {31'b0, err}, 1);
    drain();

    do_reset();
    for (int i = 1; i <= 4; i++) begin
      go("push", ST, B, CON, i, 0);
      con_q.push_back(8'(i));
    end
    @(negedge clk);
    con_ready = 1'b1;
    drv("push_pop", ST, B, CON, 5, 0);
    con_chk();
    con_q.push_back(8'h05);
    go("stat_pp", LD, W, STAT, 0, 32'h14);
    con_chk();
    ck("err_pp", {31'b0, err}, 0);
    drain();

    go("sw4", ST, W, 32'h4, 32'h5566_7788, 0);
    go("sw6_mis", ST, W, 32'h6, 32'hDEAD_BEEF, 0);
    ck("err_pre_mis", {31'b0, err}, 0);
    go("lw4", LD, W, 32'h4, 0, 32'h5566_7788);
    ck("err_mis", {31'b0, err}, 1);

    do_reset();
    ck("err_rst", {31'b0, err}, 0);
    go("lw_unmap", LD, W, 32'h4000_0000, 0, 0);
    go("idle", NO, W, 0, 0, 0);
    ck("err_unmap", {31'b0, err}, 1);

    do_reset();
    go("sw_top", ST, W, 32'hFFC, 32'hCAFE_F00D, 0);
    go("lw_top", LD, W, 32'hFFC, 0, 32'hCAFE_F00D);
    ck("err_top", {31'b0, err}, 0);
    go("lw_past", LD, W, 32'h1000, 0, 0);
    go("idle", NO, W, 0, 0, 0);
    ck("err_past", {31'b0, err}, 1);

    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFF;
    drv("cyc_max", LD, W, CYC, 0, 32'hFFFF_FFFF);
    release dut.cycle_q;
    go("cyc_wrap", LD, W, CYC, 0, 0);
    go("cyc_after", LD, W, CYC, 0, 1);

    go("toh1", ST, W, TOH, 1, 0);
    ck("halt_pre", {31'b0, halt}, 0);
    go("idle", NO, W, 0, 0, 0);
    ck("halt_set", {31'b0, halt}, 1);
    ck("code1", halt_code, 1);
    go("toh7", ST, W, TOH, 7, 0);
    go("lw_toh", LD, W, TOH, 0, 0);
    ck("halt_stay", {31'b0, halt}, 1);
    ck("code7", halt_code, 7);

    go("push_Z", ST, B, CON, 32'h5A, 0);
    go("idle", NO, W, 0, 0, 0);
    ck("z_valid", {31'b0, con_valid}, 1);
    do_reset();
    #2;
    ck("fin_halt", {31'b0, halt}, 0);
    ck("fin_err", {31'b0, err}, 0);
    ck("fin_valid", {31'b0, con_valid}, 0);
    ck("fin_data", {24'b0, con_data}, 0);
    go("fin_valid2", NO, W, 0, 0, 0);
    ck("fin_valid_rstpush", {31'b0, con_valid}, 0);
    go("lw10_keep", LD, W, 32'h10, 0, 32'hBEEF_AA44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
